// File: rtl/csr_access_unit.sv
// Execute-stage Zicsr initiator: decodes CSRRW/S/C(I), reads then writes the
// machine-mode CSR file, and hands the old CSR value back to write-back.
module csr_access_unit #(
    parameter int RD_TIMEOUT = 15,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            flush,
    output logic            csr_rd_en,
    output logic [11:0]     csr_rd_addr,
    input  logic            csr_rd_valid,
    input  logic [XLEN-1:0] csr_rd_data,
    output logic            csr_wr_en,
    output logic [11:0]     csr_wr_addr,
    output logic [XLEN-1:0] csr_wr_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_rd_data,
    output logic            out_illegal
);

    localparam int         CNT_W      = $clog2(RD_TIMEOUT + 1);
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ_REQ  = 3'd1,
        READ_WAIT = 3'd2,
        WRITE     = 3'd3,
        RESP      = 3'd4
    } state_t;

    // op is funct3[1:0]: 01 = write, 10 = set bits, 11 = clear bits
    function automatic logic [XLEN-1:0] csr_new_value(input logic [1:0]      op,
                                                      input logic [XLEN-1:0] old_val,
                                                      input logic [XLEN-1:0] operand);
        case (op)
            2'b10:   csr_new_value = old_val | operand;
            2'b11:   csr_new_value = old_val & ~operand;
            default: csr_new_value = operand;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              csr_rd_en_q, csr_rd_en_d;
    logic [11:0]       csr_rd_addr_q, csr_rd_addr_d;
    logic              csr_wr_en_q, csr_wr_en_d;
    logic [11:0]       csr_wr_addr_q, csr_wr_addr_d;
    logic [XLEN-1:0]   csr_wr_data_q, csr_wr_data_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_rd_we_q, out_rd_we_d;
    logic [XLEN-1:0]   out_rd_data_q, out_rd_data_d;
    logic              out_illegal_q, out_illegal_d;
    logic [11:0]       csr_addr_q, csr_addr_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic [4:0]        rd_q, rd_d;
    logic              do_read_q, do_read_d;
    logic              do_write_q, do_write_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [6:0]        dec_opcode;
    logic [2:0]        dec_funct3;
    logic [11:0]       dec_csr;
    logic [4:0]        dec_rd;
    logic [4:0]        dec_src;
    logic [XLEN-1:0]   dec_operand;
    logic              dec_rw;
    logic              dec_do_read;
    logic              dec_do_write;
    logic              dec_illegal;
    logic              accept;

    assign dec_opcode   = instr[6:0];
    assign dec_funct3   = instr[14:12];
    assign dec_csr      = instr[31:20];
    assign dec_rd       = instr[11:7];
    assign dec_src      = instr[19:15];
    assign dec_operand  = dec_funct3[2] ? {{(XLEN-5){1'b0}}, dec_src} : rs1_data;
    assign dec_rw       = (dec_funct3[1:0] == 2'b01);
    assign dec_do_read  = !(dec_rw && (dec_rd == 5'd0));
    assign dec_do_write = dec_rw || (dec_src != 5'd0);
    // Read-only CSRs live in the 0xC00-0xFFF quadrant; only an actual write faults.
    assign dec_illegal  = (dec_opcode != OPC_SYSTEM) || (dec_funct3[1:0] == 2'b00) ||
                          (dec_do_write && (dec_csr[11:10] == 2'b11));
    // A flush in IDLE kills the instruction presented in the same cycle.
    assign accept       = in_valid && in_ready_q && !flush;

    // Next-state and next-output computation for the access sequence
    always_comb begin
        state_d       = state_q;
        in_ready_d    = in_ready_q;
        csr_rd_en_d   = 1'b0;
        csr_rd_addr_d = csr_rd_addr_q;
        csr_wr_en_d   = 1'b0;
        csr_wr_addr_d = csr_wr_addr_q;
        csr_wr_data_d = csr_wr_data_q;
        out_valid_d   = out_valid_q;
        out_rd_d      = out_rd_q;
        out_rd_we_d   = out_rd_we_q;
        out_rd_data_d = out_rd_data_q;
        out_illegal_d = out_illegal_q;
        csr_addr_d    = csr_addr_q;
        op_d          = op_q;
        operand_d     = operand_q;
        rd_d          = rd_q;
        do_read_d     = do_read_q;
        do_write_d    = do_write_q;
        old_d         = old_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    in_ready_d = 1'b0;
                    csr_addr_d = dec_csr;
                    op_d       = dec_funct3[1:0];
                    operand_d  = dec_operand;
                    rd_d       = dec_rd;
                    do_read_d  = dec_do_read;
                    do_write_d = dec_do_write;
                    old_d      = {XLEN{1'b0}};
                    if (dec_illegal) begin
                        state_d       = RESP;
                        out_valid_d   = 1'b1;
                        out_rd_d      = dec_rd;
                        out_rd_we_d   = 1'b0;
                        out_rd_data_d = {XLEN{1'b0}};
                        out_illegal_d = 1'b1;
                    end else if (dec_do_read) begin
                        state_d       = READ_REQ;
                        csr_rd_en_d   = 1'b1;
                        csr_rd_addr_d = dec_csr;
                    end else begin
                        state_d       = WRITE;
                        csr_wr_en_d   = 1'b1;
                        csr_wr_addr_d = dec_csr;
                        csr_wr_data_d = csr_new_value(dec_funct3[1:0], {XLEN{1'b0}}, dec_operand);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ_REQ: begin
                if (flush) begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                end else begin
                    state_d = READ_WAIT;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            READ_WAIT: begin
                if (flush) begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                end else if (csr_rd_valid) begin
                    old_d = csr_rd_data;
                    if (do_write_q) begin
                        state_d       = WRITE;
                        csr_wr_en_d   = 1'b1;
                        csr_wr_addr_d = csr_addr_q;
                        csr_wr_data_d = csr_new_value(op_q, csr_rd_data, operand_q);
                    end else begin
                        state_d       = RESP;
                        out_valid_d   = 1'b1;
                        out_rd_d      = rd_q;
                        out_rd_we_d   = (rd_q != 5'd0);
                        out_rd_data_d = csr_rd_data;
                        out_illegal_d = 1'b0;
                    end
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    // This is the RD_TIMEOUT-th empty cycle: abort without writing.
                    cnt_d         = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d       = RESP;
                    out_valid_d   = 1'b1;
                    out_rd_d      = rd_q;
                    out_rd_we_d   = 1'b0;
                    out_rd_data_d = {XLEN{1'b0}};
                    out_illegal_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            WRITE: begin
                state_d       = RESP;
                out_valid_d   = 1'b1;
                out_rd_d      = rd_q;
                out_rd_we_d   = do_read_q && (rd_q != 5'd0);
                out_rd_data_d = do_read_q ? old_q : {XLEN{1'b0}};
                out_illegal_d = 1'b0;
            end
            RESP: begin
                if (out_ready) begin
                    state_d       = IDLE;
                    in_ready_d    = 1'b1;
                    out_valid_d   = 1'b0;
                    out_rd_we_d   = 1'b0;
                    out_illegal_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b1;
            csr_rd_en_q   <= 1'b0;
            csr_rd_addr_q <= 12'd0;
            csr_wr_en_q   <= 1'b0;
            csr_wr_addr_q <= 12'd0;
            csr_wr_data_q <= {XLEN{1'b0}};
            out_valid_q   <= 1'b0;
            out_rd_q      <= 5'd0;
            out_rd_we_q   <= 1'b0;
            out_rd_data_q <= {XLEN{1'b0}};
            out_illegal_q <= 1'b0;
            csr_addr_q    <= 12'd0;
            op_q          <= 2'd0;
            operand_q     <= {XLEN{1'b0}};
            rd_q          <= 5'd0;
            do_read_q     <= 1'b0;
            do_write_q    <= 1'b0;
            old_q         <= {XLEN{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            csr_rd_en_q   <= csr_rd_en_d;
            csr_rd_addr_q <= csr_rd_addr_d;
            csr_wr_en_q   <= csr_wr_en_d;
            csr_wr_addr_q <= csr_wr_addr_d;
            csr_wr_data_q <= csr_wr_data_d;
            out_valid_q   <= out_valid_d;
            out_rd_q      <= out_rd_d;
            out_rd_we_q   <= out_rd_we_d;
            out_rd_data_q <= out_rd_data_d;
            out_illegal_q <= out_illegal_d;
            csr_addr_q    <= csr_addr_d;
            op_q          <= op_d;
            operand_q     <= operand_d;
            rd_q          <= rd_d;
            do_read_q     <= do_read_d;
            do_write_q    <= do_write_d;
            old_q         <= old_d;
            cnt_q         <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign csr_rd_en   = csr_rd_en_q;
    assign csr_rd_addr = csr_rd_addr_q;
    assign csr_wr_en   = csr_wr_en_q;
    assign csr_wr_addr = csr_wr_addr_q;
    assign csr_wr_data = csr_wr_data_q;
    assign out_valid   = out_valid_q;
    assign out_rd      = out_rd_q;
    assign out_rd_we   = out_rd_we_q;
    assign out_rd_data = out_rd_data_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit: directed Zicsr vectors push expected
// CSR writes and responses; a negedge monitor pops and compares them.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic        flush = 1'b0;
    logic        csr_rd_en;
    logic [11:0] csr_rd_addr;
    logic        csr_rd_valid = 1'b0;
    logic [31:0] csr_rd_data = 32'd0;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_rd_data;
    logic        out_illegal;

    int cyc = 0;
    int t_acc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct { logic [11:0] addr; logic [31:0] data; int off; } wr_t;
    typedef struct { logic [4:0] rd; logic we; logic [31:0] data; logic ill; int off; } rsp_t;
    wr_t  wr_q[$];
    rsp_t rsp_q[$];

    csr_access_unit #(.RD_TIMEOUT(15), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .flush(flush),
        .csr_rd_en(csr_rd_en), .csr_rd_addr(csr_rd_addr),
        .csr_rd_valid(csr_rd_valid), .csr_rd_data(csr_rd_data),
        .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_rd_data(out_rd_data), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle offset %0d)", name, act, exp, cyc - t_acc);
    endtask

    task automatic exp_wr(input logic [11:0] a, input logic [31:0] d, input int off);
        wr_t w;
        w.addr = a; w.data = d; w.off = off;
        wr_q.push_back(w);
    endtask

    task automatic exp_rsp(input logic [4:0] rd, input logic we, input logic [31:0] d,
                           input logic ill, input int off);
        rsp_t r;
        r.rd = rd; r.we = we; r.data = d; r.ill = ill; r.off = off;
        rsp_q.push_back(r);
    endtask

    // Monitor: compare every write pulse and response handshake with the scoreboard
    always @(negedge clk) begin : monitor
        wr_t  w;
        rsp_t r;
        if (rst !== 1'b1) begin
            if (csr_rd_en && csr_wr_en) check("rd_wr_overlap", {31'd0, csr_wr_en}, 32'd0);
            if (csr_wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", {31'd0, csr_wr_en}, 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", {20'd0, csr_wr_addr}, {20'd0, w.addr});
                    check("wr_data", csr_wr_data, w.data);
                    check("wr_cycle", cyc - t_acc, w.off);
                end
            end
            if (out_valid && out_ready) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_rd", {27'd0, out_rd}, {27'd0, r.rd});
                    check("rsp_rd_we", {31'd0, out_rd_we}, {31'd0, r.we});
                    check("rsp_rd_data", out_rd_data, r.data);
                    check("rsp_illegal", {31'd0, out_illegal}, {31'd0, r.ill});
                    check("rsp_cycle", cyc - t_acc, r.off);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue one instruction, model the CSR file read latency (lat=0: never answers)
    task automatic run_txn(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] old,
                           input int lat, input int rd_off_exp, input logic [11:0] rd_addr_exp,
                           input bit exp_resp, input int hold, input int flush_off);
        int          countdown = 0;
        int          n_rd = 0;
        int          rd_off = 0;
        int          off = 0;
        int          limit;
        bit          done = 1'b0;
        bit          stable;
        logic [11:0] rd_addr_seen = 12'd0;
        logic [38:0] snap;
        limit = exp_resp ? 40 : 8;
        check("idle_ready", {31'd0, in_ready}, 32'd1);
        instr = ins; rs1_data = rs1; in_valid = 1'b1; t_acc = cyc;
        for (int k = 0; k < limit && !done; k++) begin
            step();
            in_valid = 1'b0;
            csr_rd_valid = 1'b0;
            off = cyc - t_acc;
            flush = (off == flush_off);
            if (countdown == 1) begin csr_rd_valid = 1'b1; csr_rd_data = old; end
            if (countdown > 0) countdown--;
            if (csr_rd_en) begin n_rd++; rd_off = off; rd_addr_seen = csr_rd_addr; countdown = lat; end
            if (flush_off > 0 && !exp_resp && off == flush_off + 1)
                check("flush_to_idle", {31'd0, in_ready}, 32'd1);
            if (out_valid) begin
                if (hold > 0) begin
                    snap = {out_rd, out_rd_we, out_illegal, out_rd_data};
                    out_ready = 1'b0;
                    check("busy_not_ready", {31'd0, in_ready}, 32'd0);
                    repeat (hold) begin
                        step();
                        stable = (out_valid === 1'b1) && (in_ready === 1'b0) &&
                                 ({out_rd, out_rd_we, out_illegal, out_rd_data} === snap);
                        check("hold_stable", {31'd0, stable}, 32'd1);
                    end
                    out_ready = 1'b1;
                end
                done = 1'b1;
            end
        end
        flush = 1'b0;
        csr_rd_valid = 1'b0;
        if (exp_resp) check("resp_seen", {31'd0, done}, 32'd1);
        if (rd_off_exp == 0) begin
            check("rd_en_count", n_rd, 32'd0);
        end else begin
            check("rd_en_count", n_rd, 32'd1);
            check("rd_en_cycle", rd_off, rd_off_exp);
            check("rd_addr", {20'd0, rd_addr_seen}, {20'd0, rd_addr_exp});
        end
        step();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        repeat (3) step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_rd_en", {31'd0, csr_rd_en}, 32'd0);
        check("rst_wr_en", {31'd0, csr_wr_en}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_rd_we", {31'd0, out_rd_we}, 32'd0);
        check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        check("rst_out_rd_data", out_rd_data, 32'd0);
        rst = 1'b0;
        step();

        // CSRRW x5,0x340,x6
        exp_wr(12'h340, 32'hDEADBEEF, 3); exp_rsp(5'd5, 1'b1, 32'h11, 1'b0, 4);
        run_txn(32'h340312F3, 32'hDEADBEEF, 32'h11, 1, 1, 12'h340, 1'b1, 0, 0);
        // CSRRS x7,0x300,x8 and CSRRC x7,0x300,x8
        exp_wr(12'h300, 32'h1808, 3); exp_rsp(5'd7, 1'b1, 32'h1800, 1'b0, 4);
        run_txn(32'h300423F3, 32'h8, 32'h1800, 1, 1, 12'h300, 1'b1, 0, 0);
        exp_wr(12'h300, 32'h1800, 3); exp_rsp(5'd7, 1'b1, 32'h1800, 1'b0, 4);
        run_txn(32'h300433F3, 32'h8, 32'h1800, 1, 1, 12'h300, 1'b1, 0, 0);
        // CSRRS x9,0x342,x0: read only
        exp_rsp(5'd9, 1'b1, 32'hB, 1'b0, 3);
        run_txn(32'h342024F3, 32'hFFFF0000, 32'hB, 1, 1, 12'h342, 1'b1, 0, 0);
        // CSRRSI x3,0x305,5: zimm operand, rs1_data ignored
        exp_wr(12'h305, 32'h15, 3); exp_rsp(5'd3, 1'b1, 32'h10, 1'b0, 4);
        run_txn(32'h3052E1F3, 32'hFFFFFFFF, 32'h10, 1, 1, 12'h305, 1'b1, 0, 0);
        // CSRRW x0,0x340,x6: write only
        exp_wr(12'h340, 32'h12345678, 1); exp_rsp(5'd0, 1'b0, 32'h0, 1'b0, 2);
        run_txn(32'h34031073, 32'h12345678, 32'h0, 1, 0, 12'h0, 1'b1, 0, 0);
        // Write to read-only CSR 0xF11, then funct3=100
        exp_rsp(5'd1, 1'b0, 32'h0, 1'b1, 1);
        run_txn(32'hF11110F3, 32'h5, 32'h0, 1, 0, 12'h0, 1'b1, 0, 0);
        exp_rsp(5'd5, 1'b0, 32'h0, 1'b1, 1);
        run_txn(32'h340342F3, 32'h5, 32'h0, 1, 0, 12'h0, 1'b1, 0, 0);
        // Read timeout: 15 cycles in READ_WAIT, then hold out_ready low 5 cycles
        exp_rsp(5'd5, 1'b0, 32'h0, 1'b1, 22);
        run_txn(32'h340312F3, 32'h1, 32'h0, 0, 1, 12'h340, 1'b1, 5, 0);
        // Flush in READ_WAIT: late read data must be ignored, nothing issued
        run_txn(32'h340312F3, 32'h1, 32'h77, 2, 1, 12'h340, 1'b0, 0, 2);
        // Flush during WRITE: committed, write and response still happen
        exp_wr(12'h340, 32'hA5A5A5A5, 1); exp_rsp(5'd0, 1'b0, 32'h0, 1'b0, 2);
        run_txn(32'h34031073, 32'hA5A5A5A5, 32'h0, 1, 0, 12'h0, 1'b1, 0, 1);

        // Flush in IDLE drops the accept
        instr = 32'h340312F3; in_valid = 1'b1; flush = 1'b1; t_acc = cyc;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_ready", {31'd0, in_ready}, 32'd1);
        check("flush_idle_no_rd", {31'd0, csr_rd_en}, 32'd0);
        repeat (3) step();

        // Reset in READ_WAIT
        instr = 32'h340312F3; rs1_data = 32'h1; in_valid = 1'b1; t_acc = cyc;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstmid_rd_addr", {20'd0, csr_rd_addr}, 32'd0);
        check("rstmid_wr_en", {31'd0, csr_wr_en}, 32'd0);
        check("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstmid_illegal", {31'd0, out_illegal}, 32'd0);
        rst = 1'b0;
        repeat (4) step();

        check("wr_queue_empty", wr_q.size(), 32'd0);
        check("rsp_queue_empty", rsp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
